// File: rtl/clock_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clock_seq_pkg : state encoding and counter sizing for clock_lock_sequencer
// Revision      : 1.0
// ---------------------------------------------------------------------------
package clock_seq_pkg;

   typedef enum logic [2:0] {
      MEM_RST   = 3'd0,
      MEM_WAIT  = 3'd1,
      TMDS_RST  = 3'd2,
      TMDS_WAIT = 3'd3,
      SETTLE    = 3'd4,
      RUN       = 3'd5
   } seq_state_e;

   // One counter serves every timed state, so it is sized for the longest wait.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lock_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lock_filter : 2-FF synchronizer plus saturating run counter for a PLL LOCK
// Revision    : 1.0
// ---------------------------------------------------------------------------
module lock_filter #(
   parameter int unsigned LOCK_FILTER = 8
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic lock_i,
   output logic locked_o
);

   localparam int unsigned FW = (LOCK_FILTER < 1) ? 1 : $clog2(LOCK_FILTER + 1);
   localparam logic [FW-1:0] RUN_MAX = FW'(LOCK_FILTER);

   logic          sync1_q;
   logic          sync2_q;
   logic [FW-1:0] run_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         run_q   <= '0;
      end else begin
         sync1_q <= lock_i;
         sync2_q <= sync1_q;
         if (!sync2_q)
            run_q <= '0;
         else if (run_q != RUN_MAX)
            run_q <= run_q + 1'b1;
      end
   end

   // Gating with sync2_q makes a single low sample drop the lock immediately.
   assign locked_o = sync2_q && (run_q == RUN_MAX);

endmodule
`default_nettype wire

// File: rtl/clock_lock_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clock_lock_sequencer : sequences memory PLL then TMDS PLL, supervises locks
// Revision             : 1.0
// ---------------------------------------------------------------------------
module clock_lock_sequencer
   import clock_seq_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_FILTER    = 8,
   parameter int unsigned LOCK_TIMEOUT   = 1_000_000,
   parameter int unsigned SETTLE_CYCLES  = 1024,
   parameter int unsigned MAX_RETRY      = 7
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       mem_lock_i,
   input  logic       tmds_lock_i,
   output logic       pll_mem_reset_o,
   output logic       pll_tmds_reset_o,
   output logic       mem_ready_o,
   output logic       tmds_ready_o,
   output logic [2:0] state_o,
   output logic [3:0] retry_count_o,
   output logic       fail_o
);

   localparam int unsigned CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   logic mem_locked;
   logic tmds_locked;
   logic timeout_hit;

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       retry_q, retry_d;
   logic             fail_q, fail_d;
   logic             pll_mem_rst_q, pll_tmds_rst_q, mem_ready_q, tmds_ready_q;

   lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_mem_filter (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .lock_i   (mem_lock_i),
      .locked_o (mem_locked)
   );

   lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_tmds_filter (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .lock_i   (tmds_lock_i),
      .locked_o (tmds_locked)
   );

   // Lock loss is checked before timeouts and progress; MEM loss beats TMDS loss.
   always_comb begin
      state_d     = state_q;
      timeout_hit = 1'b0;
      case (state_q)
         MEM_RST: begin
            if (cnt_q == RST_LAST) state_d = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (mem_locked) state_d = TMDS_RST;
            else if (cnt_q == TO_LAST) begin
               state_d     = MEM_RST;
               timeout_hit = 1'b1;
            end
         end
         TMDS_RST: begin
            if (!mem_locked) state_d = MEM_RST;
            else if (cnt_q == RST_LAST) state_d = TMDS_WAIT;
         end
         TMDS_WAIT: begin
            if (!mem_locked) state_d = MEM_RST;
            else if (tmds_locked) state_d = SETTLE;
            else if (cnt_q == TO_LAST) begin
               state_d     = TMDS_RST;
               timeout_hit = 1'b1;
            end
         end
         SETTLE: begin
            if (!mem_locked) state_d = MEM_RST;
            else if (!tmds_locked) state_d = TMDS_RST;
            else if (cnt_q == SETTLE_LAST) state_d = RUN;
         end
         RUN: begin
            if (!mem_locked) state_d = MEM_RST;
            else if (!tmds_locked) state_d = TMDS_RST;
         end
         default: state_d = MEM_RST;
      endcase
   end

   always_comb begin
      if (state_d != state_q)   cnt_d = '0;
      else if (state_q == RUN)  cnt_d = cnt_q;
      else                      cnt_d = cnt_q + 1'b1;
      retry_d = (timeout_hit && (retry_q != 4'hF)) ? retry_q + 4'd1 : retry_q;
      fail_d  = fail_q | ({28'd0, retry_d} >= MAX_RETRY);
   end

   // Outputs decode the next state so they switch on the same edge as state_q.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q        <= MEM_RST;
         cnt_q          <= '0;
         retry_q        <= '0;
         fail_q         <= 1'b0;
         pll_mem_rst_q  <= 1'b1;
         pll_tmds_rst_q <= 1'b1;
         mem_ready_q    <= 1'b0;
         tmds_ready_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         retry_q        <= retry_d;
         fail_q         <= fail_d;
         pll_mem_rst_q  <= (state_d == MEM_RST);
         pll_tmds_rst_q <= (state_d inside {MEM_RST, MEM_WAIT, TMDS_RST});
         mem_ready_q    <= !(state_d inside {MEM_RST, MEM_WAIT});
         tmds_ready_q   <= (state_d == RUN);
      end
   end

   assign pll_mem_reset_o  = pll_mem_rst_q;
   assign pll_tmds_reset_o = pll_tmds_rst_q;
   assign mem_ready_o      = mem_ready_q;
   assign tmds_ready_o     = tmds_ready_q;
   assign state_o          = state_q;
   assign retry_count_o    = retry_q;
   assign fail_o           = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_lock_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_clock_lock_sequencer : scoreboard bench for clock_lock_sequencer
// Revision                : 1.0
// ---------------------------------------------------------------------------
module tb_clock_lock_sequencer;
   import clock_seq_pkg::*;

   logic       clk = 1'b0;
   logic       reset_i, mem_lock_i, tmds_lock_i;
   logic       pll_mem_reset_o, pll_tmds_reset_o, mem_ready_o, tmds_ready_o, fail_o;
   logic [2:0] state_o;
   logic [3:0] retry_count_o;

   clock_lock_sequencer #(
      .PLL_RST_CYCLES (4),
      .LOCK_FILTER    (3),
      .LOCK_TIMEOUT   (50),
      .SETTLE_CYCLES  (8),
      .MAX_RETRY      (3)
   ) dut (
      .clk_i            (clk),
      .reset_i          (reset_i),
      .mem_lock_i       (mem_lock_i),
      .tmds_lock_i      (tmds_lock_i),
      .pll_mem_reset_o  (pll_mem_reset_o),
      .pll_tmds_reset_o (pll_tmds_reset_o),
      .mem_ready_o      (mem_ready_o),
      .tmds_ready_o     (tmds_ready_o),
      .state_o          (state_o),
      .retry_count_o    (retry_count_o),
      .fail_o           (fail_o)
   );

   typedef struct {
      string       name;
      int          cyc;
      logic [11:0] vec;
   } exp_t;

   exp_t        expq[$];
   int          cyc   = 0;
   int          total = 0;
   int          bad   = 0;
   bit          mon_en = 1'b0;
   bit          have_prev = 1'b0;
   logic [11:0] prev_v;

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   function automatic logic [11:0] vec_of(input logic [2:0] st, input logic pmr, input logic ptr,
                                          input logic mr, input logic tr, input logic [3:0] rc,
                                          input logic f);
      return {st, pmr, ptr, mr, tr, rc, f};
   endfunction

   task automatic push(input string n, input int at, input logic [11:0] v);
      exp_t e;
      e.name = n;
      e.cyc  = at;
      e.vec  = v;
      expq.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every change of the observed output vector is one DUT event.
   initial forever begin
      logic [11:0] cur;
      exp_t        e;
      @(negedge clk);
      cur = {state_o, pll_mem_reset_o, pll_tmds_reset_o, mem_ready_o, tmds_ready_o,
             retry_count_o, fail_o};
      if (mon_en && (!have_prev || cur !== prev_v)) begin
         have_prev = 1'b1;
         prev_v    = cur;
         total     = total + 1;
         if (expq.size() == 0) begin
            bad = bad + 1;
            $display("FAIL unexpected_event: cycle=%0d got=%h, required no change", cyc, cur);
         end else begin
            e = expq.pop_front();
            if (e.cyc != cyc || e.vec !== cur) begin
               bad = bad + 1;
               $display("FAIL %s: got cycle=%0d vec=%h, required cycle=%0d vec=%h",
                        e.name, cyc, cur, e.cyc, e.vec);
            end
         end
      end
   end

   initial begin
      int c, w, x;
      reset_i = 1'b1; mem_lock_i = 1'b0; tmds_lock_i = 1'b0;
      tick(2);
      push("reset_values", cyc, vec_of(MEM_RST, 1, 1, 0, 0, 0, 0));
      mon_en = 1'b1;
      tick(1);

      // Happy path
      reset_i = 1'b0;
      push("mem_pll_release", cyc + 4, vec_of(MEM_WAIT, 0, 1, 0, 0, 0, 0));
      tick(4); tick(10);
      mem_lock_i = 1'b1;
      push("mem_ready_rise", cyc + 6, vec_of(TMDS_RST, 0, 1, 1, 0, 0, 0));
      tick(6);
      push("tmds_pll_release", cyc + 4, vec_of(TMDS_WAIT, 0, 0, 1, 0, 0, 0));
      tick(4); tick(10);
      tmds_lock_i = 1'b1;
      push("settle_entry", cyc + 6, vec_of(SETTLE, 0, 0, 1, 0, 0, 0));
      push("tmds_ready_rise", cyc + 14, vec_of(RUN, 0, 0, 1, 1, 0, 0));
      tick(19);

      // One-cycle TMDS lock drop in RUN
      c = cyc;
      tmds_lock_i = 1'b0;
      tick(1);
      tmds_lock_i = 1'b1;
      push("tmds_loss", c + 3, vec_of(TMDS_RST, 0, 1, 1, 0, 0, 0));
      push("tmds_loss_release", c + 7, vec_of(TMDS_WAIT, 0, 0, 1, 0, 0, 0));
      push("tmds_loss_settle", c + 8, vec_of(SETTLE, 0, 0, 1, 0, 0, 0));
      push("tmds_loss_run", c + 16, vec_of(RUN, 0, 0, 1, 1, 0, 0));
      tick(20);

      // Both locks lost together in RUN
      c = cyc;
      mem_lock_i = 1'b0; tmds_lock_i = 1'b0;
      push("dual_loss", c + 3, vec_of(MEM_RST, 1, 1, 0, 0, 0, 0));
      push("dual_loss_release", c + 7, vec_of(MEM_WAIT, 0, 1, 0, 0, 0, 0));
      w = c + 7;
      tick(9);

      // Two-cycle glitch in MEM_WAIT, then MEM lock held low through three timeouts
      mem_lock_i = 1'b1;
      tick(2);
      mem_lock_i = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         push($sformatf("mem_timeout_%0d", k), w + 54 * (k - 1) + 50,
              vec_of(MEM_RST, 1, 1, 0, 0, 4'(k), (k >= 3)));
         push($sformatf("mem_retry_wait_%0d", k), w + 54 * k,
              vec_of(MEM_WAIT, 0, 1, 0, 0, 4'(k), (k >= 3)));
      end
      tick(w + 165 - cyc);

      // Relock with FAIL sticky, then reset in SETTLE
      x = cyc;
      mem_lock_i = 1'b1; tmds_lock_i = 1'b1;
      push("relock_mem", x + 6, vec_of(TMDS_RST, 0, 1, 1, 0, 3, 1));
      push("relock_tmds_wait", x + 10, vec_of(TMDS_WAIT, 0, 0, 1, 0, 3, 1));
      push("relock_settle", x + 11, vec_of(SETTLE, 0, 0, 1, 0, 3, 1));
      tick(13);
      reset_i = 1'b1;
      push("reset_mid_settle", cyc + 1, vec_of(MEM_RST, 1, 1, 0, 0, 0, 0));
      tick(4);

      total = total + 1;
      if (expq.size() != 0) begin
         bad = bad + 1;
         $display("FAIL missing_events: pending=%0d next=%s, required 0 pending",
                  expq.size(), expq[0].name);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
